// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 raster timing constants shared by the timing generator and renderers
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Half-open window test lo <= v < hi on raster coordinates.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel/line counters with registered sync, blank and coordinate outputs
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_pkg::V_BACK
) (
  input  logic               vga_clk,
  input  logic               reset,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               frame_start,
  output logic               line_start
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_range_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [COORD_W-1:0] hc_q, hc_d;
  logic [COORD_W-1:0] vc_q, vc_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               blank_q, blank_d;
  logic               frame_start_q, frame_start_d;
  logic               line_start_q, line_start_d;
  logic               h_wrap;

  // Decode from the next counter values so every output flop moves on the
  // same edge as the counters and DrawX/DrawY stay coherent with the flags.
  always_comb begin
    h_wrap = (hc_q == H_LAST);
    hc_d   = h_wrap ? '0 : hc_q + 1'b1;
    vc_d   = vc_q;
    if (h_wrap) begin
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end

    blank_d       = (hc_d < H_VIS) && (vc_d < V_VIS);
    hs_d          = !in_window(hc_d, HS_START, HS_END);
    vs_d          = !in_window(vc_d, VS_START, VS_END);
    line_start_d  = (hc_d == '0);
    frame_start_d = (hc_d == '0) && (vc_d == '0);
  end

  // Reset parks on the last pixel of the frame so release lands on (0,0).
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q          <= H_LAST;
      vc_q          <= V_LAST;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

endmodule
